// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status strobes out.
// With UART_RX_PARITY_EN defined the bundle also carries parity_err.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    modport master (output rx, input data, valid, frame_err, busy, parity_err);
    modport slave  (input rx, output data, valid, frame_err, busy, parity_err);
`else
    modport master (output rx, input data, valid, frame_err, busy);
    modport slave  (input rx, output data, valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with single-cycle valid/frame_err strobes.
// Define UART_RX_PARITY_EN for 8E1 reception with a parity_err strobe.
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int RX_BAUD  = 115200
) (
    input logic      clk,
    input logic      rst_n,
    uart_rx_if.slave u
);
    localparam int BIT_CNT  = CLK_FREQ / RX_BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CW       = $clog2(BIT_CNT);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;
    logic          bit_end, fall;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d, perr_q, perr_d;
`endif

    assign fall    = !s2_q && prev_q;
    assign bit_end = cnt_q == CW'(BIT_CNT - 1);

    always_comb begin
        s1_d    = u.rx;
        s2_d    = s1_q;
        prev_d  = s2_q;
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = fall ? START : IDLE;
            end
            START: if (cnt_q == CW'(HALF_CNT - 1)) begin
                // a line back high at mid start bit was only a glitch
                state_d = s2_q ? IDLE : DATA;
                cnt_d   = '0;
                idx_d   = '0;
            end
            DATA: if (bit_end) begin
                shift_d[idx_q] = s2_q;
                cnt_d          = '0;
                idx_d          = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (idx_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (bit_end) begin
                par_d   = s2_q;
                cnt_d   = '0;
                state_d = STOP;
`else
                if (idx_q == 3'd7) state_d = STOP;
`endif
            end
            STOP: if (bit_end) begin
                // leave at mid stop bit so a back-to-back start edge is caught
                state_d = IDLE;
                cnt_d   = '0;
                ferr_d  = !s2_q;
`ifdef UART_RX_PARITY_EN
                perr_d  = s2_q && par_q != ^shift_q;
                valid_d = s2_q && par_q == ^shift_q;
`else
                valid_d = s2_q;
`endif
                data_d  = valid_d ? shift_q : data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign u.data      = data_q;
    assign u.valid     = valid_q;
    assign u.frame_err = ferr_q;
    assign u.busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
    assign u.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench; a 434 clk/bit receiver for the directed frames and an
// 8 clk/bit receiver for the 256-byte loopback. Define UART_RX_PARITY_EN for 8E1.
module tb_uart_rx;
    localparam int BIT  = 50_000_000 / 115200;
    localparam int HALF = BIT / 2;
    localparam int FBIT = 800_000 / 100_000;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // pin-to-strobe, counting both the cycle the start bit is driven in and the strobe cycle
    localparam int LAT = 3 + HALF + (NB - 1) * BIT + 1;

    typedef struct packed {logic [1:0] kind; logic [7:0] data;} ev_t;
    localparam logic [1:0] KV = 2'd0, KF = 2'd1, KP = 2'd2;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    int     vectors = 0;
    int     errors  = 0;
    int     both_cnt = 0;
    longint cyc = 0;
    ev_t    exp_q[$], obs_q[$], exp2_q[$], obs2_q[$];
    longint t_q[$];

    uart_rx_if ifa ();
    uart_rx_if ifb ();
    uart_rx dut (.clk(clk), .rst_n(rst_n), .u(ifa));
    uart_rx #(.CLK_FREQ(800_000), .RX_BAUD(100_000)) dut_f (.clk(clk), .rst_n(rst_n), .u(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifa.valid) begin
            obs_q.push_back({KV, ifa.data});
            t_q.push_back(cyc);
        end
        if (ifa.frame_err) obs_q.push_back({KF, ifa.data});
        if (ifb.valid) obs2_q.push_back({KV, ifb.data});
        if (ifb.frame_err) obs2_q.push_back({KF, ifb.data});
`ifdef UART_RX_PARITY_EN
        if (ifa.parity_err) obs_q.push_back({KP, ifa.data});
        if (ifb.parity_err) obs2_q.push_back({KP, ifb.data});
        if (int'(ifa.valid) + int'(ifa.frame_err) + int'(ifa.parity_err) > 1 ||
            int'(ifb.valid) + int'(ifb.frame_err) + int'(ifb.parity_err) > 1)
            both_cnt <= both_cnt + 1;
`else
        if ((ifa.valid && ifa.frame_err) || (ifb.valid && ifb.frame_err)) both_cnt <= both_cnt + 1;
`endif
    end

    task automatic drive(input bit fast, input logic v);
        if (fast) ifb.rx = v;
        else ifa.rx = v;
        repeat (fast ? FBIT : BIT) @(negedge clk);
    endtask

    task automatic send(input bit fast, input logic [7:0] b, input logic par_flip, input logic stop);
        drive(fast, 1'b0);
        for (int i = 0; i < 8; i++) drive(fast, b[i]);
`ifdef UART_RX_PARITY_EN
        drive(fast, ^b ^ par_flip);
`endif
        drive(fast, stop);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        vectors += 5;
        if (ifa.data !== 8'h00) begin errors++; $display("FAIL reset data: got %h want 00", ifa.data); end
        if (ifa.valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", ifa.valid); end
        if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b want 0", ifa.frame_err); end
        if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", ifa.busy); end
        if (ifb.busy !== 1'b0) begin errors++; $display("FAIL reset fast busy: got %b want 0", ifb.busy); end
`ifdef UART_RX_PARITY_EN
        vectors++;
        if (ifa.parity_err !== 1'b0) begin errors++; $display("FAIL reset parity_err: got %b want 0", ifa.parity_err); end
`endif
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_basic();
        ev_t e, o;
        longint t0;
        logic seen = 1'b0, busy_at = 1'b1, busy_pre = 1'b0, prev_busy = 1'b0;
        t_q.delete();
        exp_q.push_back({KV, 8'h55});
        t0 = cyc;
        fork
            send(1'b0, 8'h55, 1'b0, 1'b1);
            for (int i = 0; i < LAT + 20; i++) begin
                @(negedge clk);
                if (ifa.valid && !seen) begin
                    seen = 1'b1;
                    busy_at = ifa.busy;
                    busy_pre = prev_busy;
                end
                prev_busy = ifa.busy;
            end
        join
        ifa.rx = 1'b1;
        repeat (BIT) @(negedge clk);
        vectors += 4;
        if (busy_pre !== 1'b1) begin errors++; $display("FAIL basic busy before valid: got %b want 1", busy_pre); end
        if (busy_at !== 1'b0) begin errors++; $display("FAIL basic busy at valid: got %b want 0", busy_at); end
        if (ifa.data !== 8'h55) begin errors++; $display("FAIL basic data held: got %h want 55", ifa.data); end
        if (t_q.size() == 0 || t_q[0] - t0 + 1 !== longint'(LAT)) begin
            errors++;
            $display("FAIL basic latency: got %0d want %0d", t_q.size() ? t_q[0] - t0 + 1 : -1, LAT);
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin errors++; $display("FAIL basic event: got kind %0d data %h want kind %0d data %h", o.kind, o.data, e.kind, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        exp_q.push_back({KV, 8'h00});
        exp_q.push_back({KV, 8'hFF});
        send(1'b0, 8'h00, 1'b0, 1'b1);
        send(1'b0, 8'hFF, 1'b0, 1'b1);
        ifa.rx = 1'b1;
        repeat (BIT) @(negedge clk);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin errors++; $display("FAIL b2b event: got kind %0d data %h want kind %0d data %h", o.kind, o.data, e.kind, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_frame_err();
        ev_t e, o;
        exp_q.push_back({KF, 8'hFF});
        exp_q.push_back({KV, 8'h3C});
        send(1'b0, 8'hA5, 1'b0, 1'b0);
        ifa.rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        vectors++;
        if (ifa.data !== 8'hFF) begin errors++; $display("FAIL ferr data kept: got %h want ff", ifa.data); end
        send(1'b0, 8'h3C, 1'b0, 1'b1);
        ifa.rx = 1'b1;
        repeat (BIT) @(negedge clk);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL ferr count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin errors++; $display("FAIL ferr event: got kind %0d data %h want kind %0d data %h", o.kind, o.data, e.kind, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        logic busy_seen = 1'b0, busy_mid = 1'b0, busy_end = 1'b1;
        ifa.rx = 1'b0;
        for (int i = 0; i < 240; i++) begin
            if (i == 100) ifa.rx = 1'b1;
            @(negedge clk);
            if (ifa.busy) busy_seen = 1'b1;
            if (i == 210) busy_mid = ifa.busy;
            if (i == 225) busy_end = ifa.busy;
        end
        repeat (BIT) @(negedge clk);
        vectors += 4;
        if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch busy rise: got %b want 1", busy_seen); end
        if (busy_mid !== 1'b1) begin errors++; $display("FAIL glitch busy at 211: got %b want 1", busy_mid); end
        if (busy_end !== 1'b0) begin errors++; $display("FAIL glitch busy at 226: got %b want 0", busy_end); end
        if (obs_q.size() !== 0) begin errors++; $display("FAIL glitch events: got %0d want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        logic b_pre = 1'b0;
        exp_q.push_back({KV, 8'h69});
        fork
            send(1'b0, 8'h96, 1'b0, 1'b1);
            begin
                repeat (5 * BIT + HALF) @(negedge clk);
                b_pre = ifa.busy;
                rst_n = 1'b0;
                @(negedge clk);
                vectors += 5;
                if (b_pre !== 1'b1) begin errors++; $display("FAIL rstmid busy before: got %b want 1", b_pre); end
                if (ifa.data !== 8'h00) begin errors++; $display("FAIL rstmid data: got %h want 00", ifa.data); end
                if (ifa.valid !== 1'b0) begin errors++; $display("FAIL rstmid valid: got %b want 0", ifa.valid); end
                if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL rstmid frame_err: got %b want 0", ifa.frame_err); end
                if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b want 0", ifa.busy); end
            end
        join
        ifa.rx = 1'b1;
        repeat (BIT) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);
        send(1'b0, 8'h69, 1'b0, 1'b1);
        ifa.rx = 1'b1;
        repeat (BIT) @(negedge clk);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin errors++; $display("FAIL rstmid event: got kind %0d data %h want kind %0d data %h", o.kind, o.data, e.kind, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        ev_t e, o;
        exp_q.push_back({KP, 8'h69});
        exp_q.push_back({KF, 8'h69});
        exp_q.push_back({KV, 8'h01});
        send(1'b0, 8'h01, 1'b1, 1'b1);
        send(1'b0, 8'h5A, 1'b1, 1'b0);
        ifa.rx = 1'b1;
        repeat (BIT) @(negedge clk);
        send(1'b0, 8'h01, 1'b0, 1'b1);
        ifa.rx = 1'b1;
        repeat (BIT) @(negedge clk);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL parity count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin errors++; $display("FAIL parity event: got kind %0d data %h want kind %0d data %h", o.kind, o.data, e.kind, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    task automatic test_loopback();
        ev_t e, o;
        for (int i = 0; i < 256; i++) begin
            exp2_q.push_back({KV, 8'(i)});
            send(1'b1, 8'(i), 1'b0, 1'b1);
        end
        ifb.rx = 1'b1;
        repeat (4 * FBIT) @(negedge clk);
        vectors++;
        if (obs2_q.size() !== exp2_q.size()) begin errors++; $display("FAIL loop count: got %0d want %0d", obs2_q.size(), exp2_q.size()); end
        while (exp2_q.size() > 0 && obs2_q.size() > 0) begin
            e = exp2_q.pop_front(); o = obs2_q.pop_front(); vectors++;
            if (o !== e) begin errors++; $display("FAIL loop event: got kind %0d data %h want kind %0d data %h", o.kind, o.data, e.kind, e.data); end
        end
        exp2_q.delete(); obs2_q.delete();
    endtask

    task automatic test_exclusive();
        vectors++;
        if (both_cnt !== 0) begin errors++; $display("FAIL exclusive strobes: got %0d overlapping cycles want 0", both_cnt); end
    endtask

    initial begin
        ifa.rx = 1'b1;
        ifb.rx = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_loopback();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
